// File: rtl/dmem_axi_lite_master.sv
// AXI4-Lite initiator for the core data-memory port; one outstanding transaction, all AXI outputs registered.
// Latency: 4 cycles counting the sample cycle with a zero-wait slave; dmem_* waits until dmem_ready.
module dmem_axi_lite_master #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [2:0]            AXI_PROT   = 3'b000,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA  = 32'hDEADBEEF
) (
  input  logic                      cpu_clk,
  input  logic                      s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]     dmem_addr,
  input  logic [DATA_WIDTH-1:0]     dmem_write_data,
  input  logic                      dmem_read,
  input  logic                      dmem_write,
  input  logic [DATA_WIDTH/8-1:0]   dmem_byte_enable,
  output logic [DATA_WIDTH-1:0]     dmem_read_data,
  output logic                      dmem_ready,
  output logic                      bus_error,
  output logic [7:0]                err_count,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]              state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    aw_done;
  logic                    w_done;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    b_err;
  logic                    r_err;
  logic                    resp_vld;
  logic                    resp_err;

  assign aw_hs    = m_axi_awvalid && m_axi_awready;
  assign w_hs     = m_axi_wvalid && m_axi_wready;
  assign b_err    = (m_axi_bresp == 2'b10) || (m_axi_bresp == 2'b11);
  assign r_err    = (m_axi_rresp == 2'b10) || (m_axi_rresp == 2'b11);
  assign resp_vld = ((state == WR_RESP) && m_axi_bvalid) || ((state == RD_DATA) && m_axi_rvalid);
  assign resp_err = (state == WR_RESP) ? b_err : r_err;

  // One address register serves both channels since only one transaction is ever in flight.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_awprot = AXI_PROT;
  assign m_axi_arprot = AXI_PROT;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;

  always_ff @(posedge cpu_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state          <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      m_axi_awvalid  <= 1'b0;
      m_axi_wvalid   <= 1'b0;
      m_axi_bready   <= 1'b0;
      m_axi_arvalid  <= 1'b0;
      m_axi_rready   <= 1'b0;
      dmem_ready     <= 1'b0;
      bus_error      <= 1'b0;
      dmem_read_data <= '0;
      err_count      <= 8'h00;
    end else begin
      dmem_ready <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (dmem_write) begin
            if (dmem_byte_enable == '0) begin
              state      <= DONE;
              dmem_ready <= 1'b1;
            end else begin
              addr_q        <= dmem_addr & ~ADDR_WIDTH'(3);
              wdata_q       <= dmem_write_data;
              wstrb_q       <= dmem_byte_enable;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= WR_REQ;
            end
          end else if (dmem_read) begin
            addr_q        <= dmem_addr & ~ADDR_WIDTH'(3);
            m_axi_arvalid <= 1'b1;
            state         <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) m_axi_bready <= 1'b0;
        end
        RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready   <= 1'b0;
            dmem_read_data <= (m_axi_rresp == 2'b00) ? m_axi_rdata : ERR_RDATA;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (resp_vld) begin
        state      <= DONE;
        dmem_ready <= 1'b1;
        bus_error  <= resp_err;
        if (resp_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
